// File: rtl/airlock_pkg.sv
// Shared types and default timing constants for the airlock chamber controller.
package airlock_pkg;

    typedef enum logic [1:0] {
        EVACUATED   = 2'd0,
        FILLING     = 2'd1,
        PRESSURIZED = 2'd2,
        EVACUATING  = 2'd3
    } state_e;

    localparam int unsigned FILL_CYCLES_DEF = 7;
    localparam int unsigned EVAC_CYCLES_DEF = 8;
    localparam int unsigned CNT_W_DEF       = 4;

endpackage : airlock_pkg

// File: rtl/airlock_chamber_ctrl_if.sv
// Request, port-sense and status bundle between the input stage and the chamber controller.
interface airlock_chamber_ctrl_if
    import airlock_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
);

    logic             fill_req;
    logic             evac_req;
    logic             outer_closed;
    logic             inner_closed;
    logic             pressurized;
    logic             evacuated;
    logic             busy;
    logic             hold;
    logic             reject;
    logic             outer_unlock;
    logic             inner_unlock;
    logic [CNT_W-1:0] remaining;

    modport master (
        output fill_req, evac_req, outer_closed, inner_closed,
        input  pressurized, evacuated, busy, hold, reject,
               outer_unlock, inner_unlock, remaining
    );

    modport slave (
        input  fill_req, evac_req, outer_closed, inner_closed,
        output pressurized, evacuated, busy, hold, reject,
               outer_unlock, inner_unlock, remaining
    );

endinterface : airlock_chamber_ctrl_if

// File: rtl/airlock_timer.sv
// Loadable down-counter for the fill/evacuate sequence; done flags the final counted cycle.
module airlock_timer
    import airlock_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] remaining_o,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign remaining_o = cnt_q;
    assign done_o      = en_i && (cnt_q == CNT_W'(1));

endmodule : airlock_timer

// File: rtl/airlock_chamber_ctrl.sv
// Chamber-side airlock sequencer: validates fill/evacuate requests against port state,
// runs the timed sequence and drives registered status and unlock permissives.
module airlock_chamber_ctrl
    import airlock_pkg::*;
#(
    parameter int unsigned FILL_CYCLES = FILL_CYCLES_DEF,
    parameter int unsigned EVAC_CYCLES = EVAC_CYCLES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    airlock_chamber_ctrl_if.slave  bus
);

    state_e           state_q, state_d;
    logic             reject_q, reject_d;
    logic             hold_q, hold_d;
    logic             outer_unlock_q, outer_unlock_d;
    logic             inner_unlock_q, inner_unlock_d;

    logic             both_closed;
    logic             any_req;
    logic             accept;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_en;
    logic             tmr_done;
    logic [CNT_W-1:0] tmr_remaining;

    assign both_closed = bus.outer_closed && bus.inner_closed;
    assign any_req     = bus.fill_req || bus.evac_req;

    airlock_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .load_i      (tmr_load),
        .load_val_i  (tmr_load_val),
        .en_i        (tmr_en),
        .remaining_o (tmr_remaining),
        .done_o      (tmr_done)
    );

    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_en       = 1'b0;

        unique case (state_q)
            EVACUATED: begin
                if (bus.fill_req && !bus.evac_req && both_closed) begin
                    state_d      = FILLING;
                    accept       = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_load_val = CNT_W'(FILL_CYCLES);
                end
            end
            PRESSURIZED: begin
                if (bus.evac_req && !bus.fill_req && both_closed) begin
                    state_d      = EVACUATING;
                    accept       = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_load_val = CNT_W'(EVAC_CYCLES);
                end
            end
            FILLING: begin
                tmr_en = both_closed;
                if (tmr_done) begin
                    state_d = PRESSURIZED;
                end
            end
            EVACUATING: begin
                tmr_en = both_closed;
                if (tmr_done) begin
                    state_d = EVACUATED;
                end
            end
            default: begin
                state_d = EVACUATED;
            end
        endcase

        // Requests during a sequence are never accepted, so they always reject.
        reject_d       = any_req && !accept;
        hold_d         = ((state_q == FILLING) || (state_q == EVACUATING)) && !both_closed;
        outer_unlock_d = (state_d == EVACUATED)   && bus.inner_closed;
        inner_unlock_d = (state_d == PRESSURIZED) && bus.outer_closed;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= EVACUATED;
            reject_q       <= 1'b0;
            hold_q         <= 1'b0;
            outer_unlock_q <= 1'b1;
            inner_unlock_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            reject_q       <= reject_d;
            hold_q         <= hold_d;
            outer_unlock_q <= outer_unlock_d;
            inner_unlock_q <= inner_unlock_d;
        end
    end

    assign bus.pressurized  = (state_q == PRESSURIZED);
    assign bus.evacuated    = (state_q == EVACUATED);
    assign bus.busy         = (state_q == FILLING) || (state_q == EVACUATING);
    assign bus.hold         = hold_q;
    assign bus.reject       = reject_q;
    assign bus.outer_unlock = outer_unlock_q;
    assign bus.inner_unlock = inner_unlock_q;
    assign bus.remaining    = tmr_remaining;

endmodule : airlock_chamber_ctrl

// File: tb/tb_airlock_chamber_ctrl.sv
// Directed-vector bench for airlock_chamber_ctrl with hand-computed expectations.
module tb_airlock_chamber_ctrl;
    import airlock_pkg::*;

    // Status vector bit order: {Pressurized, Evacuated, Busy, Hold, Reject, OuterUnlock, InnerUnlock}
    localparam logic [6:0] S_IDLE_EVAC  = 7'b0100010;
    localparam logic [6:0] S_REJ_EVAC   = 7'b0100110;
    localparam logic [6:0] S_BUSY       = 7'b0010000;
    localparam logic [6:0] S_BUSY_HOLD  = 7'b0011000;
    localparam logic [6:0] S_BUSY_REJ   = 7'b0010100;
    localparam logic [6:0] S_IDLE_PRES  = 7'b1000001;
    localparam logic [6:0] S_REJ_PRES   = 7'b1000101;

    logic clk;
    logic rst_ni;
    int unsigned vec_cnt;
    int unsigned err_cnt;

    airlock_chamber_ctrl_if #(.CNT_W(4)) bus ();

    airlock_chamber_ctrl #(
        .FILL_CYCLES (7),
        .EVAC_CYCLES (8),
        .CNT_W       (4)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] status();
        return {bus.pressurized, bus.evacuated, bus.busy, bus.hold,
                bus.reject, bus.outer_unlock, bus.inner_unlock};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_ni           = 1'b0;
        bus.fill_req     = 1'b0;
        bus.evac_req     = 1'b0;
        bus.outer_closed = 1'b1;
        bus.inner_closed = 1'b1;
        tick();
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vec_cnt++;
            if (status() !== S_IDLE_EVAC) begin
                err_cnt++;
                $display("FAIL reset_status cyc%0d: got %b want %b", i, status(), S_IDLE_EVAC);
            end
            vec_cnt++;
            if (bus.remaining !== 4'd0) begin
                err_cnt++;
                $display("FAIL reset_remaining cyc%0d: got %0d want 0", i, bus.remaining);
            end
        end
    endtask

    task automatic test_reject_idle();
        bus.outer_closed = 1'b0;
        bus.fill_req     = 1'b1;
        tick();
        bus.fill_req = 1'b0;
        vec_cnt++;
        if (status() !== S_REJ_EVAC || bus.remaining !== 4'd0) begin
            err_cnt++;
            $display("FAIL fill_port_open: got %b/%0d want %b/0", status(), bus.remaining, S_REJ_EVAC);
        end
        tick();
        vec_cnt++;
        if (status() !== S_IDLE_EVAC) begin
            err_cnt++;
            $display("FAIL fill_port_open_after: got %b want %b", status(), S_IDLE_EVAC);
        end
        bus.outer_closed = 1'b1;
        bus.evac_req     = 1'b1;
        tick();
        bus.evac_req = 1'b0;
        vec_cnt++;
        if (status() !== S_REJ_EVAC || bus.remaining !== 4'd0) begin
            err_cnt++;
            $display("FAIL evac_in_evacuated: got %b/%0d want %b/0", status(), bus.remaining, S_REJ_EVAC);
        end
        tick();
        vec_cnt++;
        if (status() !== S_IDLE_EVAC) begin
            err_cnt++;
            $display("FAIL evac_in_evacuated_after: got %b want %b", status(), S_IDLE_EVAC);
        end
    endtask

    task automatic test_fill();
        bus.fill_req = 1'b1;
        tick();
        bus.fill_req = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            vec_cnt++;
            if (status() !== S_BUSY || bus.remaining !== 4'(8 - k)) begin
                err_cnt++;
                $display("FAIL fill_count t+%0d: got %b/%0d want %b/%0d",
                         k, status(), bus.remaining, S_BUSY, 8 - k);
            end
            tick();
        end
        vec_cnt++;
        if (status() !== S_IDLE_PRES || bus.remaining !== 4'd0) begin
            err_cnt++;
            $display("FAIL fill_done t+8: got %b/%0d want %b/0", status(), bus.remaining, S_IDLE_PRES);
        end
    endtask

    task automatic test_dual_request();
        bus.fill_req = 1'b1;
        bus.evac_req = 1'b1;
        tick();
        bus.fill_req = 1'b0;
        bus.evac_req = 1'b0;
        vec_cnt++;
        if (status() !== S_REJ_PRES || bus.remaining !== 4'd0) begin
            err_cnt++;
            $display("FAIL dual_req: got %b/%0d want %b/0", status(), bus.remaining, S_REJ_PRES);
        end
        tick();
        vec_cnt++;
        if (status() !== S_IDLE_PRES) begin
            err_cnt++;
            $display("FAIL dual_req_after: got %b want %b", status(), S_IDLE_PRES);
        end
    endtask

    task automatic test_evac();
        logic [6:0] exp_s;
        bus.evac_req = 1'b1;
        tick();
        bus.evac_req = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            exp_s = (k == 4) ? S_BUSY_REJ : S_BUSY;
            vec_cnt++;
            if (status() !== exp_s || bus.remaining !== 4'(9 - k)) begin
                err_cnt++;
                $display("FAIL evac_count t+%0d: got %b/%0d want %b/%0d",
                         k, status(), bus.remaining, exp_s, 9 - k);
            end
            if (k == 3) bus.fill_req = 1'b1;
            tick();
            bus.fill_req = 1'b0;
        end
        vec_cnt++;
        if (status() !== S_IDLE_EVAC || bus.remaining !== 4'd0) begin
            err_cnt++;
            $display("FAIL evac_done t+9: got %b/%0d want %b/0", status(), bus.remaining, S_IDLE_EVAC);
        end
    endtask

    task automatic test_hold();
        logic [6:0] exp_s;
        int         exp_r;
        bus.fill_req = 1'b1;
        tick();
        bus.fill_req = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k <= 3) begin
                exp_r = 8 - k;
                exp_s = S_BUSY;
            end else if (k <= 6) begin
                exp_r = 5;
                exp_s = S_BUSY_HOLD;
            end else begin
                exp_r = 11 - k;
                exp_s = S_BUSY;
            end
            vec_cnt++;
            if (status() !== exp_s || bus.remaining !== 4'(exp_r)) begin
                err_cnt++;
                $display("FAIL hold_fill t+%0d: got %b/%0d want %b/%0d",
                         k, status(), bus.remaining, exp_s, exp_r);
            end
            bus.inner_closed = !((k >= 3) && (k <= 5));
            tick();
        end
        vec_cnt++;
        if (status() !== S_IDLE_PRES || bus.remaining !== 4'd0) begin
            err_cnt++;
            $display("FAIL hold_done t+11: got %b/%0d want %b/0", status(), bus.remaining, S_IDLE_PRES);
        end
    endtask

    task automatic test_reset_mid();
        bus.evac_req = 1'b1;
        tick();
        bus.evac_req = 1'b0;
        repeat (4) tick();
        vec_cnt++;
        if (status() !== S_BUSY || bus.remaining !== 4'd4) begin
            err_cnt++;
            $display("FAIL pre_reset t+5: got %b/%0d want %b/4", status(), bus.remaining, S_BUSY);
        end
        rst_ni = 1'b0;
        #2;
        vec_cnt++;
        if (status() !== S_IDLE_EVAC || bus.remaining !== 4'd0) begin
            err_cnt++;
            $display("FAIL async_reset: got %b/%0d want %b/0", status(), bus.remaining, S_IDLE_EVAC);
        end
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_back_to_back();
        bus.fill_req = 1'b1;
        tick();
        bus.fill_req = 1'b0;
        vec_cnt++;
        if (status() !== S_BUSY || bus.remaining !== 4'd7) begin
            err_cnt++;
            $display("FAIL first_req_after_reset: got %b/%0d want %b/7", status(), bus.remaining, S_BUSY);
        end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        test_reset();
        test_reject_idle();
        test_fill();
        test_dual_request();
        test_evac();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_airlock_chamber_ctrl

// File: doc/airlock_chamber_ctrl.md
# airlock_chamber_ctrl

Chamber-side responder for the airlock interlock. Accepts single-cycle fill/pressurize and evacuate request pulses from the user-input conditioning stage, and checks them against the outer and inner port closed states. Runs a timed fill or evacuate sequence and reports chamber status, port-unlock permissives and a remaining-time count for the seven-segment display.

## Interface
Parameters:
- FILL_CYCLES, 7: clock cycles to fill and pressurize; legal range 1..2^CNT_W-1.
- EVAC_CYCLES, 8: clock cycles to evacuate; legal range 1..2^CNT_W-1.
- CNT_W, 4: width of the remaining-time counter.

Ports:
- Clock, in, 1: the single clock; in the system it is the divided clock.
- Reset, in, 1: asynchronous, active-low.
- FillReq, in, 1: one-cycle request pulse to fill and pressurize.
- EvacReq, in, 1: one-cycle request pulse to evacuate.
- OuterClosed, in, 1: 1 = outer port closed.
- InnerClosed, in, 1: 1 = inner port closed.
- Pressurized, out, 1: chamber is at inner level.
- Evacuated, out, 1: chamber is at outer level.
- Busy, out, 1: a fill or evacuate is in progress.
- Hold, out, 1: the sequence is paused because a port is open.
- Reject, out, 1: one-cycle pulse; the request was refused.
- OuterUnlock, out, 1: outer port may be opened.
- InnerUnlock, out, 1: inner port may be opened.
- Remaining, out, CNT_W: cycles left in the current sequence; 0 when not busy.

## Operation
- There are four states: EVACUATED, FILLING, PRESSURIZED, EVACUATING. The reset state is EVACUATED.
- Reset values of the outputs:
  - Evacuated=1, OuterUnlock=1.
  - Pressurized=0, Busy=0, Hold=0, Reject=0, InnerUnlock=0, Remaining=0.
- EVACUATED:
  - If FillReq=1, EvacReq=0, OuterClosed=1 and InnerClosed=1: go to FILLING and load Remaining=FILL_CYCLES.
  - Any other request in this state pulses Reject. This includes EvacReq, and FillReq while a port is open.
- PRESSURIZED:
  - If EvacReq=1, FillReq=0 and both ports are closed: go to EVACUATING and load Remaining=EVAC_CYCLES.
  - Any other request pulses Reject.
- FILLING and EVACUATING:
  - While both ports are closed, Remaining decrements by 1 each cycle.
  - If either port is open, Remaining freezes and Hold=1. Counting resumes on the first cycle both ports are closed again.
  - When Remaining is 1 and counting is enabled, the next state is PRESSURIZED (from FILLING) or EVACUATED (from EVACUATING), and Remaining becomes 0.
  - Any request in these states pulses Reject and does not alter the sequence.
- FillReq and EvacReq asserted in the same cycle: both are ignored and Reject pulses, in every state.
- Status outputs:
  - Pressurized=1 only in PRESSURIZED.
  - Evacuated=1 only in EVACUATED.
  - Busy=1 in FILLING and EVACUATING.
- Unlock permissives (registered):
  - OuterUnlock=1 iff next state is EVACUATED and InnerClosed=1.
  - InnerUnlock=1 iff next state is PRESSURIZED and OuterClosed=1.
  - The two unlocks are never 1 in the same cycle.
- Counter arithmetic is unsigned CNT_W. Remaining never wraps below 0; a decrement at 0 is illegal and never occurs.

## Timing
- All outputs are registered and change only on the rising edge of Clock. The only exception is the asynchronous assertion of Reset.
- A request accepted at edge t gives Busy=1 and Remaining=N at t+1, where N = FILL_CYCLES or EVAC_CYCLES.
- With no holds, Remaining=1 at t+N, and Busy=0 with Pressurized or Evacuated=1 at t+N+1. Each held cycle adds one cycle.
- Reject is high for exactly the cycle after the offending request edge, and is never high for two consecutive cycles from one pulse.
- Reset asserted mid-sequence returns the block to EVACUATED immediately. This is done with reset values; no partial state is kept.
- After Reset deasserts, the first request is sampled at the first rising edge.
- Requests are assumed already synchronized and one cycle wide, so the block itself contains no synchronizer.

## Structure
- Shared package airlock_pkg holds:
  - the state enum (EVACUATED, FILLING, PRESSURIZED, EVACUATING);
  - the default FILL_CYCLES, EVAC_CYCLES and CNT_W constants.
- One sub-module, airlock_timer:
  - holds a loadable CNT_W down-counter with a load value, a count enable, the Remaining output and a done flag (Remaining==1 and enabled);
  - its reset is asynchronous and active-low.
- The state machine and the unlock and Reject registers live in airlock_chamber_ctrl.

## Test plan
- Reset, then idle 3 cycles: Evacuated=1, OuterUnlock=1, Busy=0, Remaining=0, Reject=0.
- Both ports closed, FillReq pulse at t (FILL_CYCLES=7):
  - Busy=1, Remaining=7 at t+1.
  - Remaining counts 7..1.
  - Pressurized=1, InnerUnlock=1, Busy=0 at t+8.
- FillReq with OuterClosed=0: Reject=1 for one cycle, state stays EVACUATED, Remaining=0.
- Inner port opened for 3 cycles mid-fill:
  - Hold=1 and Remaining frozen during those 3 cycles.
  - Completion arrives at t+11.
- From PRESSURIZED, EvacReq and FillReq in the same cycle: Reject pulse, state unchanged.
  - A following EvacReq then completes with Evacuated=1 at t+9 (EVAC_CYCLES=8).
- Reset asserted at Remaining=4 during evacuate: all outputs immediately take their reset values, and OuterUnlock=1 once InnerClosed=1.
